input_layer_pingpong_controller: RTL and testbench

- Parametrised successor to the single-bit input layer controller.
- Accepts a raster stream of NUM_PIXELS multi-bit pixels.
- Keeps only active pixels (value > THRESHOLD) as (index, value) entries in a fill bank, then swaps fill and drain banks so the next frame streams in while the hidden layer dequeues the previous one.
- Sits between the external pixel source and the first hidden-layer neuron array.

---
 rtl/input_layer_pingpong_controller_if.sv | 34 +++
 rtl/input_layer_pingpong_controller.sv | 74 +++++++
 tb/tb_input_layer_pingpong_controller.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/input_layer_pingpong_controller_if.sv
// input_layer_pingpong_controller_if: pixel-source, consumer and status signals of the ping-pong input layer.
// valueOut exists only when INPUT_LAYER_PIXEL_VALUE_OUT_EN is defined.
interface input_layer_pingpong_controller_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int INDEX_WIDTH = 10
);
  logic inputsInbound;
  logic pixelValid;
  logic [PIXEL_WIDTH-1:0] pixelValue;
  logic readyForInputs;
  logic dequeue;
  logic outValid;
  logic [INDEX_WIDTH-1:0] indexOut;
`ifdef INPUT_LAYER_PIXEL_VALUE_OUT_EN
  logic [PIXEL_WIDTH-1:0] valueOut;
`endif
  logic queueEmpty;
  logic frameReady;
  logic [INDEX_WIDTH-1:0] activeCount;
  modport master (
`ifdef INPUT_LAYER_PIXEL_VALUE_OUT_EN
    input valueOut,
`endif
    output inputsInbound, pixelValid, pixelValue, dequeue,
    input readyForInputs, outValid, indexOut, queueEmpty, frameReady, activeCount
  );
  modport slave (
`ifdef INPUT_LAYER_PIXEL_VALUE_OUT_EN
    output valueOut,
`endif
    input inputsInbound, pixelValid, pixelValue, dequeue,
    output readyForInputs, outValid, indexOut, queueEmpty, frameReady, activeCount
  );
endinterface

// File: rtl/input_layer_pingpong_controller.sv
// input_layer_pingpong_controller: thresholds a pixel raster into ping-pong banks of active entries.
// Define INPUT_LAYER_PIXEL_VALUE_OUT_EN to store {index, value} and drive valueOut; otherwise index only.
module input_layer_pingpong_controller #(
  parameter int NUM_PIXELS = 784,
  parameter int PIXEL_WIDTH = 8,
  parameter int INDEX_WIDTH = 10,
  parameter int THRESHOLD = 0
) (
  input logic clk,
  input logic reset,
  input_layer_pingpong_controller_if.slave bus
);
  localparam int AW = NUM_PIXELS > 1 ? $clog2(NUM_PIXELS) : 1;
`ifdef INPUT_LAYER_PIXEL_VALUE_OUT_EN
  localparam int EW = INDEX_WIDTH + PIXEL_WIDTH;
`else
  localparam int EW = INDEX_WIDTH;
`endif
  logic [EW-1:0] bank [2][NUM_PIXELS];
  logic [EW-1:0] entry, head;
  logic [INDEX_WIDTH-1:0] fillCount, fillActive, drainPtr, drainCount;
  logic fillFull, bankSel, frameReady, accept, active, outValid, swap;
  assign accept = bus.pixelValid & bus.inputsInbound & ~fillFull;
  assign active = bus.pixelValue > PIXEL_WIDTH'(THRESHOLD);
  assign outValid = drainPtr < drainCount;
  assign swap = fillFull & ~outValid;
`ifdef INPUT_LAYER_PIXEL_VALUE_OUT_EN
  assign entry = {fillCount, bus.pixelValue};
  assign bus.valueOut = outValid ? head[PIXEL_WIDTH-1:0] : '0;
`else
  assign entry = fillCount;
`endif
  assign head = bank[~bankSel][drainPtr[AW-1:0]];
  assign bus.indexOut = outValid ? head[EW-1 -: INDEX_WIDTH] : '0;
  assign bus.readyForInputs = ~fillFull;
  assign bus.outValid = outValid;
  assign bus.queueEmpty = ~outValid;
  assign bus.frameReady = frameReady;
  assign bus.activeCount = drainCount;
  // storage carries no reset so it can map onto RAM; drain outputs are gated by outValid instead
  always_ff @(posedge clk)
    if (accept & active) bank[bankSel][fillActive[AW-1:0]] <= entry;
  always_ff @(posedge clk) begin
    if (reset) begin
      fillCount <= '0;
      fillActive <= '0;
      fillFull <= 1'b0;
      drainPtr <= '0;
      drainCount <= '0;
      bankSel <= 1'b0;
      frameReady <= 1'b0;
    end else begin
      frameReady <= swap;
      if (swap) begin
        bankSel <= ~bankSel;
        drainCount <= fillActive;
        drainPtr <= '0;
        fillFull <= 1'b0;
        fillCount <= '0;
        fillActive <= '0;
      end else begin
        if (bus.dequeue & outValid) drainPtr <= drainPtr + 1'b1;
        if (accept) begin
          fillCount <= fillCount + 1'b1;
          if (active) fillActive <= fillActive + 1'b1;
          if (fillCount == INDEX_WIDTH'(NUM_PIXELS - 1)) fillFull <= 1'b1;
        end else if (~bus.inputsInbound & ~fillFull & |fillCount) begin
          fillCount <= '0;
          fillActive <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_input_layer_pingpong_controller.sv
// tb_input_layer_pingpong_controller: table-driven frames, hand-written corner sequences, then
// randomized streaming checked against a queue-based frame model.
module tb_input_layer_pingpong_controller;
  localparam int NP = 8, PW = 8, IW = 10;
  logic clk = 1'b0, reset;
  always #5 clk = ~clk;
  input_layer_pingpong_controller_if #(.PIXEL_WIDTH(PW), .INDEX_WIDTH(IW)) bus ();
  input_layer_pingpong_controller #(.NUM_PIXELS(NP), .PIXEL_WIDTH(PW), .INDEX_WIDTH(IW), .THRESHOLD(0))
    dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct { int pix[NP]; int cnt; int idx[NP]; int val[NP]; } vec_t;
  vec_t vecs[4];
  int checks = 0, failures = 0;
  int cur[$], pend[$], drain[$];
  bit pendValid;
  int cnt, e, v8;
  bit deq, inb, pv;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic sendFrame(input int v);
    for (int i = 0; i < NP; i++) begin
      chk("ready_before_pixel", bus.readyForInputs, 1);
      bus.pixelValid = 1'b1;
      bus.pixelValue = PW'(vecs[v].pix[i]);
      @(negedge clk);
    end
    bus.pixelValid = 1'b0;
    bus.pixelValue = '0;
    chk("ready_after_last_pixel", bus.readyForInputs, 0);
  endtask
  task automatic waitFrame(input int expWait);
    int n = 0;
    while (!bus.frameReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("frame_ready_latency", n, expWait);
  endtask
  task automatic drainFrame(input int v);
    chk("active_count", bus.activeCount, vecs[v].cnt);
    for (int k = 0; k < vecs[v].cnt; k++) begin
      chk("out_valid", bus.outValid, 1);
      chk("index_out", bus.indexOut, vecs[v].idx[k]);
`ifdef INPUT_LAYER_PIXEL_VALUE_OUT_EN
      chk("value_out", bus.valueOut, vecs[v].val[k]);
`endif
      bus.dequeue = 1'b1;
      @(negedge clk);
    end
    bus.dequeue = 1'b0;
    @(negedge clk);
    chk("frame_ready_one_cycle", bus.frameReady, 0);
    chk("queue_empty_after_drain", bus.queueEmpty, 1);
    chk("out_valid_after_drain", bus.outValid, 0);
    chk("index_out_idle", bus.indexOut, 0);
  endtask
  initial begin
    vecs[0].pix = '{0, 5, 0, 0, 9, 0, 0, 1};
    vecs[0].cnt = 3;
    vecs[0].idx = '{1, 4, 7, 0, 0, 0, 0, 0};
    vecs[0].val = '{5, 9, 1, 0, 0, 0, 0, 0};
    vecs[1].pix = '{default: 0};
    vecs[1].cnt = 0;
    vecs[1].idx = '{default: 0};
    vecs[1].val = '{default: 0};
    vecs[2].pix = '{default: 255};
    vecs[2].cnt = 8;
    vecs[2].idx = '{0, 1, 2, 3, 4, 5, 6, 7};
    vecs[2].val = '{default: 255};
    vecs[3].pix = '{3, 0, 0, 0, 0, 0, 0, 200};
    vecs[3].cnt = 2;
    vecs[3].idx = '{0, 7, 0, 0, 0, 0, 0, 0};
    vecs[3].val = '{3, 200, 0, 0, 0, 0, 0, 0};
    reset = 1'b1;
    bus.inputsInbound = 1'b0;
    bus.pixelValid = 1'b0;
    bus.pixelValue = '0;
    bus.dequeue = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", bus.readyForInputs, 1);
    chk("rst_out_valid", bus.outValid, 0);
    chk("rst_index_out", bus.indexOut, 0);
    chk("rst_queue_empty", bus.queueEmpty, 1);
    chk("rst_frame_ready", bus.frameReady, 0);
    chk("rst_active_count", bus.activeCount, 0);
`ifdef INPUT_LAYER_PIXEL_VALUE_OUT_EN
    chk("rst_value_out", bus.valueOut, 0);
`endif
    bus.inputsInbound = 1'b1;
    for (int v = 0; v < 4; v++) begin
      sendFrame(v);
      waitFrame(1);
      drainFrame(v);
    end
    // second frame fills while the first is held undrained
    sendFrame(0);
    waitFrame(1);
    sendFrame(3);
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready_low", bus.readyForInputs, 0);
      chk("bp_no_swap", bus.frameReady, 0);
    end
    for (int k = 0; k < 3; k++) begin
      chk("bp_index_out", bus.indexOut, vecs[0].idx[k]);
      bus.dequeue = 1'b1;
      @(negedge clk);
    end
    bus.dequeue = 1'b0;
    chk("bp_empty_before_swap", bus.queueEmpty, 1);
    chk("bp_no_pulse_yet", bus.frameReady, 0);
    chk("bp_ready_still_low", bus.readyForInputs, 0);
    @(negedge clk);
    chk("bp_swap_pulse", bus.frameReady, 1);
    chk("bp_ready_after_swap", bus.readyForInputs, 1);
    drainFrame(3);
    // partial frame abort
    bus.pixelValid = 1'b1;
    bus.pixelValue = 8'd7;
    repeat (3) @(negedge clk);
    bus.pixelValid = 1'b0;
    bus.inputsInbound = 1'b0;
    @(negedge clk);
    bus.inputsInbound = 1'b1;
    sendFrame(0);
    waitFrame(1);
    drainFrame(0);
    // dequeue with nothing to drain
    bus.dequeue = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("empty_deq_out_valid", bus.outValid, 0);
      chk("empty_deq_queue_empty", bus.queueEmpty, 1);
    end
    bus.dequeue = 1'b0;
    sendFrame(3);
    waitFrame(1);
    drainFrame(3);
    // reset mid-drain
    sendFrame(2);
    waitFrame(1);
    bus.dequeue = 1'b1;
    repeat (2) @(negedge clk);
    bus.dequeue = 1'b0;
    chk("mid_drain_index", bus.indexOut, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_drain_out_valid", bus.outValid, 0);
    chk("rst_drain_ready", bus.readyForInputs, 1);
    chk("rst_drain_queue_empty", bus.queueEmpty, 1);
    chk("rst_drain_active_count", bus.activeCount, 0);
    chk("rst_drain_index_out", bus.indexOut, 0);
    // reset mid-frame
    bus.pixelValid = 1'b1;
    bus.pixelValue = 8'd9;
    repeat (4) @(negedge clk);
    bus.pixelValid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sendFrame(0);
    waitFrame(1);
    drainFrame(0);
    // randomized streaming against a frame-level model
    pendValid = 1'b0;
    cnt = 0;
    repeat (800) begin
      if (bus.frameReady) begin
        chk("rnd_swap_had_frame", pendValid, 1);
        chk("rnd_drain_was_empty", drain.size(), 0);
        drain = pend;
        pend.delete();
        pendValid = 1'b0;
        chk("rnd_active_count", bus.activeCount, drain.size());
      end
      chk("rnd_queue_empty", bus.queueEmpty, drain.size() == 0);
      chk("rnd_ready", bus.readyForInputs, !pendValid);
      deq = 1'($urandom % 2);
      if (deq && drain.size() > 0) begin
        e = drain.pop_front();
        chk("rnd_index_out", bus.indexOut, e / 256);
`ifdef INPUT_LAYER_PIXEL_VALUE_OUT_EN
        chk("rnd_value_out", bus.valueOut, e % 256);
`endif
      end
      inb = ($urandom % 12) != 0;
      pv = ($urandom % 4) != 0;
      v8 = ($urandom % 3 == 0) ? 0 : int'($urandom % 256);
      bus.dequeue = deq;
      bus.inputsInbound = inb;
      bus.pixelValid = pv;
      bus.pixelValue = PW'(v8);
      if (!pendValid && pv && inb) begin
        if (v8 > 0) cur.push_back(cnt * 256 + v8);
        cnt++;
        if (cnt == NP) begin
          pend = cur;
          pendValid = 1'b1;
          cur.delete();
          cnt = 0;
        end
      end else if (!inb) begin
        cur.delete();
        cnt = 0;
      end
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
